acc_sequencer: RTL
==================

# acc_sequencer

Command sequencer and arithmetic stage sitting directly upstream of the 16-bit accumulator register (`reg16`). It accepts opcode/operand commands over a valid/ready handshake, combines the operand with the register's current value (fed back from `reg16.Out`), and drives the register's `In` and `E` so that exactly one write happens per command. ADD/SUB/LOAD complete in two cycles; MUL is a 16-cycle shift-add.

## Interface
- `WIDTH`, 16: datapath width. Must match `reg16`.
- `CLK`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (low = reset asserted).
- `in_valid`  input  1  command present.
- `in_ready`  output  1  sequencer can accept a command.
- `op`  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 MUL.
- `operand`  input  WIDTH  unsigned operand.
- `acc_q`  input  WIDTH  current accumulator value; wired to `reg16.Out`.
- `reg_d`  output  WIDTH  next accumulator value; wired to `reg16.In`.
- `reg_e`  output  1  write enable; wired to `reg16.E`.
- `busy`  output  1  high in any state other than IDLE.
- `ovf`  output  1  sticky overflow/underflow flag.

## Operation
- States: IDLE, MUL, COMMIT.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture `op` and `operand`:
  - LOAD: `reg_d` <= operand; `ovf` <= 0; go to COMMIT.
  - ADD: `reg_d` <= acc_q + operand; go to COMMIT.
  - SUB: `reg_d` <= acc_q - operand; go to COMMIT.
  - MUL: load multiplicand = acc_q, multiplier = operand, product = 0, bit counter = 0; go to MUL.
- MUL: each cycle, if multiplier[0], product += multiplicand (32-bit product register); multiplicand <<= 1; multiplier >>= 1; counter++. After the 16th iteration (counter = 15), `reg_d` <= product[15:0]; go to COMMIT.
- COMMIT: `reg_e`=1 for exactly this cycle; `reg16` captures `reg_d` at the edge ending COMMIT; next state IDLE.
- Arithmetic is unsigned, modulo 2^WIDTH unless ACC_SAT_EN is defined.
- Overflow: ADD carry-out, SUB borrow (operand > acc_q), or MUL with product[31:16] != 0 sets `ovf`. Once set, `ovf` stays 1 until a LOAD commits or reset.
- `in_valid` outside IDLE is ignored. A command not accepted is not queued; the source holds `op`/`operand` until `in_ready`.
- `reg_d` holds its last value outside COMMIT; `reg_e` is 0 in every state except COMMIT.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `reg_d`=0, `reg_e`=0, `ovf`=0, `busy`=0, MUL counters cleared. `in_ready`=1 once reset is deasserted.
- LOAD/ADD/SUB: accept at edge N; COMMIT during cycle N..N+1; `acc_q` shows the result after edge N+1; `in_ready` is high again from edge N+1. Throughput is 1 command per 2 cycles.
- MUL: accept at edge N; MUL occupies 16 cycles; COMMIT follows; result appears on `acc_q` after edge N+17.
- The next command is accepted only in IDLE, which guarantees `acc_q` already reflects the previous commit (no read-after-write hazard).
- Reset asserted mid-MUL or in COMMIT: the operation is abandoned, no write occurs, and `reg_e` drops immediately. `reg16` must be reset by the same tree.
- `ovf` updates at the same edge that enters COMMIT.

## Configuration
- `ACC_SAT_EN` defined: results saturate instead of wrapping.
  - ADD overflow gives 16'hFFFF.
  - SUB underflow gives 16'h0000.
  - MUL overflow gives 16'hFFFF.
  - `ovf` is still set.
- `ACC_SAT_EN` undefined: results wrap modulo 2^16; `ovf` is set on overflow or underflow.

## Test plan
- Reset: hold `reset`=0 for 5 cycles, release → `reg_e`=0, `ovf`=0, `in_ready`=1, `busy`=0, `reg16.Out`=0.
- LOAD 5, then ADD 3 → `reg_e` pulses exactly once per command, one cycle after accept; `Out`=5, then 8; `in_ready` low only during COMMIT.
- Overflow: LOAD 2, SUB 4 → `Out`=16'hFFFE, `ovf`=1 (16'h0000 with ACC_SAT_EN). A subsequent ADD 1 leaves `ovf`=1; LOAD 7 clears it.
- MUL: LOAD 3, MUL 16'h0100 → `busy` high for 17 cycles, `Out`=16'h0300 at accept+17, `ovf`=0. Then LOAD 16'h1000, MUL 16'h0010 → `Out`=0 and `ovf`=1 (16'hFFFF with ACC_SAT_EN).
- Backpressure: assert `in_valid` with ADD 1 continuously during a MUL → no extra `reg_e` pulse; ADD is accepted only after returning to IDLE, and the final value reflects MUL then ADD.
- Reset mid-operation: start MUL, drop `reset` at cycle 8 → `reg_e` never pulses, state is IDLE and `Out`=0 after release, and the next LOAD 9 works normally.

Source files
------------

// File: rtl/acc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_sequencer_if
// Description : Command handshake bundle (valid/ready, opcode, operand)
//               feeding the accumulator sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;

  modport master (
    output in_valid,
    output op,
    output operand,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  op,
    input  operand,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acc_sequencer
// Description : Command sequencer and arithmetic stage in front of reg16.
//               One write per command; MUL is a 16-cycle shift-add.
//               Optional macro ACC_SAT_EN: saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_sequencer #(
  parameter int WIDTH = 16
) (
  input  wire logic             CLK,
  input  wire logic             reset,
  acc_sequencer_if.slave        cmd,
  input  wire logic [WIDTH-1:0] acc_q,
  output logic      [WIDTH-1:0] reg_d,
  output logic                  reg_e,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             carry_w;
  logic             borrow_w;
  logic [PW-1:0]    prod_next_w;
  logic             prod_hi_w;
  logic [WIDTH-1:0] add_res_w;
  logic [WIDTH-1:0] sub_res_w;
  logic [WIDTH-1:0] mul_res_w;

  assign sum_w       = {1'b0, acc_q} + {1'b0, cmd.operand};
  assign diff_w      = {1'b0, acc_q} - {1'b0, cmd.operand};
  assign carry_w     = sum_w[WIDTH];
  assign borrow_w    = diff_w[WIDTH];
  // Final iteration must see its own partial product, so results use the next value
  assign prod_next_w = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_hi_w   = |prod_next_w[PW-1:WIDTH];

`ifdef ACC_SAT_EN
  assign add_res_w = carry_w   ? '1 : sum_w[WIDTH-1:0];
  assign sub_res_w = borrow_w  ? '0 : diff_w[WIDTH-1:0];
  assign mul_res_w = prod_hi_w ? '1 : prod_next_w[WIDTH-1:0];
`else
  assign add_res_w = sum_w[WIDTH-1:0];
  assign sub_res_w = diff_w[WIDTH-1:0];
  assign mul_res_w = prod_next_w[WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    reg_d_d  = reg_d_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.in_valid) begin
          case (cmd.op)
            OP_LOAD: begin
              reg_d_d = cmd.operand;
              ovf_d   = 1'b0;
              state_d = S_COMMIT;
            end
            OP_ADD: begin
              reg_d_d = add_res_w;
              ovf_d   = ovf_q | carry_w;
              state_d = S_COMMIT;
            end
            OP_SUB: begin
              reg_d_d = sub_res_w;
              ovf_d   = ovf_q | borrow_w;
              state_d = S_COMMIT;
            end
            default: begin
              mcand_d  = {{WIDTH{1'b0}}, acc_q};
              mplier_d = cmd.operand;
              prod_d   = '0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
          endcase
        end
      end
      S_MUL: begin
        prod_d   = prod_next_w;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          reg_d_d = mul_res_w;
          ovf_d   = ovf_q | prod_hi_w;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      reg_d_q  <= '0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      reg_d_q  <= reg_d_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  // Decoded straight from state so an async reset kills reg_e at once
  assign cmd.in_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign reg_e        = (state_q == S_COMMIT);
  assign reg_d        = reg_d_q;
  assign ovf          = ovf_q;

endmodule
`default_nettype wire
